// File: rtl/av2_sched_pkg.sv
// Shared types and constants for the AV2 frame tile scheduler.
package av2_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_DONE    = 3'd4
  } sched_state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_OVERSIZE = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  // Size of a tile starting at origin, clipped to the frame edge.
  function automatic logic [15:0] clip_dim(input logic [15:0] total,
                                           input logic [16:0] origin,
                                           input logic [15:0] tile);
    logic [16:0] remain;
    remain = {1'b0, total} - origin;
    return (remain > {1'b0, tile}) ? tile : remain[15:0];
  endfunction

endpackage

// File: rtl/av2_tile_addr_map.sv
// Registered translation of tile-local write addresses into frame-raster
// addresses: addr = (y0 + ly) * frame_width + x0 + lx, modulo 2^32.
module av2_tile_addr_map #(
  parameter int TILE_W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  local_addr,
  input  logic [31:0]  x0,
  input  logic [31:0]  y0,
  input  logic [15:0]  frame_width,
  input  logic         wr_en,
  input  logic [127:0] data,
  output logic [31:0]  recon_addr,
  output logic [127:0] recon_data,
  output logic         recon_wr_en
);
  localparam int LOG_TW = $clog2(TILE_W);

  logic [31:0] lx;
  logic [31:0] ly;
  logic [31:0] frame_addr;

  assign lx         = local_addr & 32'(TILE_W - 1);
  assign ly         = local_addr >> LOG_TW;
  assign frame_addr = (y0 + ly) * {16'd0, frame_width} + x0 + lx;

  // One-cycle write stage; address and data only move on an accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      recon_addr  <= '0;
      recon_data  <= '0;
      recon_wr_en <= 1'b0;
    end else begin
      recon_wr_en <= wr_en;
      if (wr_en) begin
        recon_addr <= frame_addr;
        recon_data <= data;
      end
    end
  end

endmodule

// File: rtl/av2_frame_tile_scheduler.sv
// Frame-level tile sequencer: walks tiles in raster order, launches the
// decoder per tile with clipped dimensions and remaps its writes.
// Optional watchdog is built when AV2_TILE_WDOG_EN is defined.
// Decoder handshake: dec_start is a one-cycle launch; the decoder answers
// with a one-cycle dec_tile_done, honoured only while waiting on a tile.
module av2_frame_tile_scheduler
  import av2_sched_pkg::*;
#(
  parameter int TILE_W      = 64,
  parameter int TILE_H      = 64,
  parameter int MAX_TILES_X = 16,
  parameter int MAX_TILES_Y = 16,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         frame_start,
  input  logic [15:0]  frame_width,
  input  logic [15:0]  frame_height,
  output logic         dec_start,
  output logic [15:0]  dec_width,
  output logic [15:0]  dec_height,
  input  logic         dec_tile_done,
  input  logic [31:0]  dec_recon_addr,
  input  logic [127:0] dec_recon_data,
  input  logic         dec_recon_wr_en,
  output logic [31:0]  recon_addr,
  output logic [127:0] recon_data,
  output logic         recon_wr_en,
  output logic [7:0]   tile_x,
  output logic [7:0]   tile_y,
  output logic         frame_busy,
  output logic         frame_done,
  output logic [1:0]   err_code,
  output logic [2:0]   fsm_state
);
  localparam int LOG_TW = $clog2(TILE_W);
  localparam int LOG_TH = $clog2(TILE_H);
  localparam logic [31:0] WDOG_LIMIT = 32'(WDOG_CYCLES - 1);

  sched_state_t state, next_state;
  logic [15:0]  width_q, height_q;
  logic [7:0]   cols_q, rows_q;
  logic         abort_q;
  logic [16:0]  cols_in, rows_in;
  logic         empty_in, oversize_in;
  logic [7:0]   next_x, next_y;
  logic         last_tile, wdog_expired, wr_fwd;

  assign cols_in     = ({1'b0, frame_width} + 17'(TILE_W - 1)) >> LOG_TW;
  assign rows_in     = ({1'b0, frame_height} + 17'(TILE_H - 1)) >> LOG_TH;
  assign empty_in    = (frame_width == 16'd0) || (frame_height == 16'd0);
  assign oversize_in = (cols_in > 17'(MAX_TILES_X)) || (rows_in > 17'(MAX_TILES_Y));
  assign last_tile   = (tile_x == cols_q - 8'd1) && (tile_y == rows_q - 8'd1);

  assign dec_start  = (state == ST_LAUNCH);
  assign frame_busy = (state == ST_LAUNCH) || (state == ST_WAIT) || (state == ST_ADVANCE);
  assign frame_done = (state == ST_DONE);
  assign fsm_state  = state;
  // A done pulse always arrives in WAIT, so coincident writes are covered too.
  assign wr_fwd     = dec_recon_wr_en && (state == ST_WAIT);

  // Raster successor of the current tile.
  always_comb begin
    next_x = tile_x + 8'd1;
    next_y = tile_y;
    if (tile_x == cols_q - 8'd1) begin
      next_x = 8'd0;
      next_y = tile_y + 8'd1;
    end
  end

`ifdef AV2_TILE_WDOG_EN
  logic [31:0] wdog_cnt;

  // Counts cycles spent in WAIT; cleared on every launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  wdog_cnt <= '0;
    else if (state == ST_LAUNCH) wdog_cnt <= '0;
    else if (state == ST_WAIT)   wdog_cnt <= wdog_cnt + 32'd1;
  end

  assign wdog_expired = (state == ST_WAIT) && (wdog_cnt == WDOG_LIMIT);
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = ^WDOG_LIMIT;
  assign wdog_expired    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic. Empty or oversize frames pass through ADVANCE so the
  // done pulse lands two cycles after the request, like a normal last tile.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (frame_start) next_state = (empty_in || oversize_in) ? ST_ADVANCE : ST_LAUNCH;
      ST_LAUNCH:  next_state = ST_WAIT;
      ST_WAIT: begin
        if (dec_tile_done)     next_state = ST_ADVANCE;
        else if (wdog_expired) next_state = ST_DONE;
      end
      ST_ADVANCE: next_state = (abort_q || last_tile) ? ST_DONE : ST_LAUNCH;
      ST_DONE:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Frame geometry, tile position, launch dimensions and error status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q    <= '0;
      height_q   <= '0;
      cols_q     <= '0;
      rows_q     <= '0;
      abort_q    <= 1'b0;
      tile_x     <= '0;
      tile_y     <= '0;
      dec_width  <= '0;
      dec_height <= '0;
      err_code   <= ERR_NONE;
    end else begin
      case (state)
        ST_IDLE: if (frame_start) begin
          width_q  <= frame_width;
          height_q <= frame_height;
          cols_q   <= cols_in[7:0];
          rows_q   <= rows_in[7:0];
          abort_q  <= empty_in || oversize_in;
          tile_x   <= '0;
          tile_y   <= '0;
          err_code <= (!empty_in && oversize_in) ? ERR_OVERSIZE : ERR_NONE;
          if (!(empty_in || oversize_in)) begin
            dec_width  <= clip_dim(frame_width, 17'd0, 16'(TILE_W));
            dec_height <= clip_dim(frame_height, 17'd0, 16'(TILE_H));
          end
        end
        ST_WAIT: if (!dec_tile_done && wdog_expired) err_code <= ERR_TIMEOUT;
        ST_ADVANCE: if (!abort_q && !last_tile) begin
          tile_x     <= next_x;
          tile_y     <= next_y;
          dec_width  <= clip_dim(width_q, {9'd0, next_x} << LOG_TW, 16'(TILE_W));
          dec_height <= clip_dim(height_q, {9'd0, next_y} << LOG_TH, 16'(TILE_H));
        end
        default: ;
      endcase
    end
  end

  av2_tile_addr_map #(
    .TILE_W(TILE_W)
  ) u_addr_map (
    .clk         (clk),
    .rst_n       (rst_n),
    .local_addr  (dec_recon_addr),
    .x0          (32'(tile_x) << LOG_TW),
    .y0          (32'(tile_y) << LOG_TH),
    .frame_width (width_q),
    .wr_en       (wr_fwd),
    .data        (dec_recon_data),
    .recon_addr  (recon_addr),
    .recon_data  (recon_data),
    .recon_wr_en (recon_wr_en)
  );

endmodule

// File: tb/tb_av2_frame_tile_scheduler.sv
// Self-checking bench for av2_frame_tile_scheduler. Inputs change on the
// falling edge, outputs are sampled on the falling edge.
module tb_av2_frame_tile_scheduler;
  localparam int TW = 64;
  localparam int TH = 64;

  logic         clk;
  logic         rst_n;
  logic         frame_start;
  logic [15:0]  frame_width, frame_height;
  logic         dec_start;
  logic [15:0]  dec_width, dec_height;
  logic         dec_tile_done;
  logic [31:0]  dec_recon_addr;
  logic [127:0] dec_recon_data;
  logic         dec_recon_wr_en;
  logic [31:0]  recon_addr;
  logic [127:0] recon_data;
  logic         recon_wr_en;
  logic [7:0]   tile_x, tile_y;
  logic         frame_busy, frame_done;
  logic [1:0]   err_code;
  logic [2:0]   fsm_state;

  int total = 0;
  int bad   = 0;
  logic [31:0]  exp_q[$];
  logic [127:0] exp_d[$];

  av2_frame_tile_scheduler #(
    .TILE_W(TW), .TILE_H(TH), .MAX_TILES_X(16), .MAX_TILES_Y(16), .WDOG_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .frame_width(frame_width), .frame_height(frame_height),
    .dec_start(dec_start), .dec_width(dec_width), .dec_height(dec_height),
    .dec_tile_done(dec_tile_done), .dec_recon_addr(dec_recon_addr),
    .dec_recon_data(dec_recon_data), .dec_recon_wr_en(dec_recon_wr_en),
    .recon_addr(recon_addr), .recon_data(recon_data), .recon_wr_en(recon_wr_en),
    .tile_x(tile_x), .tile_y(tile_y), .frame_busy(frame_busy),
    .frame_done(frame_done), .err_code(err_code), .fsm_state(fsm_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Reference model: plain tile arithmetic.
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int clip(input int total_px, input int origin, input int tile);
    return (total_px - origin < tile) ? (total_px - origin) : tile;
  endfunction

  function automatic logic [31:0] model_addr(input int w, input int tx, input int ty,
                                             input int lx, input int ly);
    logic [63:0] a;
    a = 64'(ty * TH + ly) * 64'(w) + 64'(tx * TW + lx);
    return a[31:0];
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_dec_start"}, dec_start, 0);
    chk({tag, "_dec_width"}, dec_width, 0);
    chk({tag, "_dec_height"}, dec_height, 0);
    chk({tag, "_tile_x"}, tile_x, 0);
    chk({tag, "_tile_y"}, tile_y, 0);
    chk({tag, "_busy"}, frame_busy, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_err"}, err_code, 0);
    chk({tag, "_wr_en"}, recon_wr_en, 0);
    chk({tag, "_addr"}, recon_addr, 0);
    chk({tag, "_data"}, recon_data, 0);
  endtask

  // Drive one frame through a decoder model. dly=0 picks a random tile
  // latency, dir_local>=0 forces the first write of every tile, disturb adds
  // a stray done in LAUNCH and a frame_start while busy, abort_tile resets
  // the design during WAIT of that tile index.
  task automatic run_frame(input int w, input int h, input int dly, input int dir_local,
                           input bit disturb, input int abort_tile);
    int ntx, nty, idx;
    bit pend, want_6565;
    ntx = ceil_div(w, TW);
    nty = ceil_div(h, TH);
    idx = 0;
    want_6565 = 1'b0;
    frame_width = 16'(w); frame_height = 16'(h); frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int ty = 0; ty < nty; ty++) begin
      for (int tx = 0; tx < ntx; tx++) begin
        int dw, dh, d, nw, lx, ly;
        logic [127:0] dat;
        bit wr;
        dw = clip(w, tx * TW, TW);
        dh = clip(h, ty * TH, TH);
        chk("launch_start", dec_start, 1);
        chk("launch_width", dec_width, dw);
        chk("launch_height", dec_height, dh);
        chk("launch_tile_x", tile_x, tx);
        chk("launch_tile_y", tile_y, ty);
        chk("launch_err", err_code, 0);
        chk("launch_busy", frame_busy, 1);
        if (disturb) dec_tile_done = 1'b1;
        d = (dly > 0) ? dly : $urandom_range(3, 12);
        nw = $urandom_range(0, d - 1);
        pend = 1'b0;
        for (int c = 1; c <= d; c++) begin
          step();
          dec_tile_done = 1'b0; dec_recon_wr_en = 1'b0; frame_start = 1'b0;
          if (c == 1) chk("start_one_cycle", dec_start, 0);
          chk("wait_busy", frame_busy, 1);
          chk("wr_strobe", recon_wr_en, pend);
          if (pend) begin
            chk("wr_addr", recon_addr, exp_q.pop_front());
            chk("wr_data", recon_data, exp_d.pop_front());
            if (want_6565) chk("addr_6565", recon_addr, 32'd6565);
            pend = 1'b0; want_6565 = 1'b0;
          end
          if (idx == abort_tile && c == 2) begin
            rst_n = 1'b0;
            #1;
            check_all_zero("async_reset");
            exp_q.delete(); exp_d.delete();
            step();
            rst_n = 1'b1;
            step();
            return;
          end
          if (disturb && c == 1) begin
            frame_start = 1'b1; frame_width = 16'd7; frame_height = 16'd7;
          end
          wr = (c <= nw) || (c == 1 && dir_local >= 0) || (c == d && $urandom_range(0, 1) == 1);
          if (wr) begin
            if (c == 1 && dir_local >= 0) begin
              lx = dir_local % TW; ly = dir_local / TW;
              want_6565 = (dir_local == 65) && (w == 100) && (tx == 1) && (ty == 1);
            end else begin
              lx = $urandom_range(0, dw - 1); ly = $urandom_range(0, dh - 1);
            end
            dat = {$urandom, $urandom, $urandom, $urandom};
            dec_recon_addr = 32'(ly * TW + lx);
            dec_recon_data = dat;
            dec_recon_wr_en = 1'b1;
            exp_q.push_back(model_addr(w, tx, ty, lx, ly));
            exp_d.push_back(dat);
            pend = 1'b1;
          end
          if (c == d) dec_tile_done = 1'b1;
        end
        step();
        dec_tile_done = 1'b0; dec_recon_wr_en = 1'b0;
        chk("done_wr_strobe", recon_wr_en, pend);
        if (pend) begin
          chk("done_wr_addr", recon_addr, exp_q.pop_front());
          chk("done_wr_data", recon_data, exp_d.pop_front());
          pend = 1'b0;
        end
        chk("advance_no_start", dec_start, 0);
        chk("advance_no_done", frame_done, 0);
        step();
        idx++;
        if (tx == ntx - 1 && ty == nty - 1) begin
          chk("frame_done", frame_done, 1);
          chk("frame_done_busy", frame_busy, 0);
          chk("frame_done_err", err_code, 0);
          chk("frame_done_no_start", dec_start, 0);
          step();
          chk("frame_done_pulse", frame_done, 0);
        end
      end
    end
  endtask

  task automatic run_no_tile(input int w, input int h, input logic [1:0] e);
    frame_width = 16'(w); frame_height = 16'(h); frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("notile_start1", dec_start, 0);
    chk("notile_busy", frame_busy, 1);
    chk("notile_early_done", frame_done, 0);
    step();
    chk("notile_done", frame_done, 1);
    chk("notile_err", err_code, e);
    chk("notile_start2", dec_start, 0);
    step();
    chk("notile_done_pulse", frame_done, 0);
    chk("notile_err_held", err_code, e);
  endtask

  task automatic run_watchdog();
    int n;
    n = 0;
    frame_width = 16'd64; frame_height = 16'd64; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("wdog_launch", dec_start, 1);
    for (int i = 1; i <= 1000; i++) begin
      step();
      if (frame_done === 1'b1) begin
        n = i;
        break;
      end
    end
`ifdef AV2_TILE_WDOG_EN
    chk("wdog_latency", n, 17);
    chk("wdog_err", err_code, 2);
    step();
    chk("wdog_err_held", err_code, 2);
`else
    chk("no_wdog_done", n, 0);
    chk("no_wdog_busy", frame_busy, 1);
    chk("no_wdog_err", err_code, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
`endif
  endtask

  // Directed sequence with randomized frames mixed in.
  initial begin
    rst_n = 1'b0; frame_start = 1'b0; frame_width = '0; frame_height = '0;
    dec_tile_done = 1'b0; dec_recon_addr = '0; dec_recon_data = '0; dec_recon_wr_en = 1'b0;
    step(); step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    dec_recon_addr = 32'd5; dec_recon_data = 128'hABCD; dec_recon_wr_en = 1'b1;
    step();
    chk("idle_write_drop1", recon_wr_en, 0);
    step();
    chk("idle_write_drop2", recon_wr_en, 0);
    dec_recon_wr_en = 1'b0;
    step();

    run_frame(64, 64, 20, 0, 1'b0, -1);
    run_frame(100, 70, 0, 65, 1'b1, -1);
    run_no_tile(0, 50, 2'd0);
    run_no_tile(1100, 64, 2'd1);
    run_no_tile(64, 1100, 2'd1);
    for (int k = 0; k < 3; k++) begin
      run_frame($urandom_range(1, 300), $urandom_range(1, 200), 0, -1, 1'($urandom_range(0, 1)), -1);
    end
    run_watchdog();
    run_frame(200, 70, 0, -1, 1'b0, 2);
    run_frame(130, 10, 0, -1, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/av2_frame_tile_scheduler.md
# av2_frame_tile_scheduler

Frame-level sequencer for the simplified AV2 tile decoder. Walks a frame in raster order of fixed-size tiles, launches the decoder once per tile with clipped tile dimensions, and translates the decoder's tile-local reconstruction write addresses into frame-raster addresses. Sits between the frame control/host logic and a single `av2_tile_decoder_simplified` instance. A watchdog aborts the frame if a tile never completes.

## Interface
- `TILE_W`, 64, tile width in pixels; power of two.
- `TILE_H`, 64, tile height in pixels; power of two.
- `MAX_TILES_X`, 16, maximum tile columns per frame.
- `MAX_TILES_Y`, 16, maximum tile rows per frame.
- `WDOG_CYCLES`, 4096, maximum cycles from `dec_start` to `dec_tile_done`.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `frame_start` in 1: one-cycle request to decode a frame; sampled only in IDLE.
- `frame_width` in 16: frame width in pixels; captured at accepted `frame_start`.
- `frame_height` in 16: frame height in pixels; captured likewise.
- `dec_start` out 1: one-cycle launch pulse to the decoder.
- `dec_width` out 16: clipped width of the current tile.
- `dec_height` out 16: clipped height of the current tile.
- `dec_tile_done` in 1: decoder tile-complete pulse.
- `dec_recon_addr` in 32: tile-local pixel address, `ly*TILE_W + lx`.
- `dec_recon_data` in 128: 16 8-bit pixels.
- `dec_recon_wr_en` in 1: decoder write strobe.
- `recon_addr` out 32: frame address, `(y0+ly)*frame_width + x0+lx`.
- `recon_data` out 128: registered copy of `dec_recon_data`.
- `recon_wr_en` out 1: registered write strobe.
- `tile_x` out 8: current tile column.
- `tile_y` out 8: current tile row.
- `frame_busy` out 1: high from accepted `frame_start` until `frame_done`.
- `frame_done` out 1: one-cycle completion pulse.
- `err_code` out 2: 0 = none, 1 = oversize, 2 = timeout. Held until the next accepted `frame_start`.

## Operation
- **IDLE**
  - Accepted `frame_start` does three things: latches width and height, clears `tile_x`, `tile_y` and `err_code`, and raises `frame_busy`.
  - Width or height equal to 0 → DONE, with no tiles launched.
  - `ceil(W/TILE_W) > MAX_TILES_X` or `ceil(H/TILE_H) > MAX_TILES_Y` → `err_code=1`, then DONE with no tiles launched.
  - Otherwise → LAUNCH.
- **LAUNCH**
  - Drives `dec_start=1` for exactly one cycle.
  - Sets `dec_width = min(TILE_W, W - tile_x*TILE_W)` and `dec_height = min(TILE_H, H - tile_y*TILE_H)`.
  - `dec_width` and `dec_height` stay stable until the next LAUNCH.
  - → WAIT.
- **WAIT**
  - Waits for `dec_tile_done`, then → ADVANCE.
  - Watchdog counter counts cycles spent in WAIT.
  - Reaching `WDOG_CYCLES` without `dec_tile_done` → `err_code=2`, then DONE.
- **ADVANCE**
  - Increments `tile_x`; on wrap, resets `tile_x` to 0 and increments `tile_y`.
  - Last tile just finished → DONE; otherwise → LAUNCH.
- **DONE**
  - `frame_done=1` for one cycle and `frame_busy` drops.
  - → IDLE.
- **Write translation**
  - `lx = local[log2(TILE_W)-1:0]` and `ly = local >> log2(TILE_W)`.
  - Output address is computed modulo 2^32.
  - Writes are forwarded only when `dec_recon_wr_en` is asserted in WAIT, or in the same cycle as `dec_tile_done`.
  - Writes in any other state are dropped: `recon_wr_en` stays 0.
- **Simultaneous and out-of-state events**
  - `frame_start` outside IDLE is ignored.
  - A `dec_tile_done` pulse outside WAIT is ignored.

## Timing
- All outputs reset to 0, and the state resets to IDLE.
- Reset may arrive mid-frame; this abandons the frame with no `frame_done`.
- Accepted `frame_start` at cycle t gives `dec_start` at t+1.
- `dec_tile_done` at t gives ADVANCE at t+1 and the next `dec_start` at t+2.
- For the last tile, `frame_done` is at t+2.
- Write path latency is exactly 1 cycle: addr, data and strobe are all registered.
- A write coincident with the final `dec_tile_done` therefore appears at t+1, before `frame_done`.
- Watchdog timeout: with `dec_start` at t, DONE is entered at `t+1+WDOG_CYCLES` and `frame_done` pulses that cycle.

## Configuration
- `AV2_TILE_WDOG_EN` defined: the watchdog is present as described.
- `AV2_TILE_WDOG_EN` undefined:
  - No counter is built.
  - WAIT waits indefinitely.
  - `err_code` never takes value 2.

## Structure
- Package `av2_sched_pkg` holds:
  - the state enum (IDLE, LAUNCH, WAIT, ADVANCE, DONE);
  - the `err_code` constants `ERR_NONE`, `ERR_OVERSIZE`, `ERR_TIMEOUT`.
- One sub-module, `av2_tile_addr_map`:
  - The registered local-to-frame address translation stage.
  - Inputs: local address, `x0`, `y0`, `frame_width`, strobe and data.
  - Outputs: the registered `recon_*` signals.

## Test plan
- **Single tile:** 64x64 frame. Decoder model writes `local=0`, then pulses done 20 cycles after start.
  - Expect exactly one `dec_start`, with `dec_width=64` and `dec_height=64`.
  - Expect `recon_addr=0`, and `frame_done` 2 cycles after done.
- **Clipped multi-tile:** 100x70 frame.
  - Expect 4 launches in raster order, with dims (64,64), (36,64), (64,6), (36,6).
  - For tile (1,1), a write at `local=65` must give `recon_addr = 65*100 + 64 + 1 = 6565`.
- **Degenerate and oversize frames:**
  - width=0 → `frame_done` 2 cycles after `frame_start`, no `dec_start`, `err_code=0`.
  - width=1100 → `err_code=1`, no `dec_start`.
- **Watchdog** (`AV2_TILE_WDOG_EN` defined, `WDOG_CYCLES=16`): decoder never signals done.
  - Expect `err_code=2` and `frame_done` at `dec_start`+17.
  - Rebuilt without the macro, expect no `frame_done` within 1000 cycles.
- **Ignored inputs:**
  - `frame_start` pulsed while busy → no effect on the tile sequence.
  - Stray `dec_tile_done` in LAUNCH → ignored.
  - `dec_recon_wr_en` in IDLE → `recon_wr_en` stays 0.
- **Reset mid-frame:** assert `rst_n=0` during WAIT of tile 2.
  - All outputs go to 0 asynchronously.
  - A following `frame_start` restarts at tile (0,0).
